serial_adder: RTL
=================

Name: serial_adder

Overview:
Bit-serial adder that adds two WIDTH-bit operands LSB-first, one bit per clock, through a single full_adder cell plus a carry flip-flop. It sits directly upstream of the full_adder cell and sequences it. The block trades WIDTH cycles of latency for one-cell area. It is used wherever the team needs an area-minimal adder behind a start/done handshake.

Parameters:
WIDTH, 8, operand and sum width in bits (must be >= 1)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
A  input  WIDTH  operand A, sampled on accepted start
B  input  WIDTH  operand B, sampled on accepted start
Cin  input  1  carry-in, sampled on accepted start
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse when Sum/Cout are valid
Sum  output  WIDTH  registered sum, held until the next completion
Cout  output  1  registered carry-out, held with Sum

Behaviour:
- Reset: the block is reset asynchronously whenever rst_n=0. State is IDLE, and busy, done, Sum, Cout, the internal shift registers, the carry flip-flop and the counter are all 0. Reset asserted mid-operation aborts the addition, and no done is produced.
- States are IDLE, RUN and DONE. The encodings are defined in the package.
- IDLE or DONE with start=1 at edge E0:
  - Load A and B into shift registers, load Cin into the carry flip-flop, clear the counter, and go to RUN.
  - busy=1 from E0.
  - Without start, DONE returns to IDLE and IDLE holds.
- RUN, each edge Ek (k=1..WIDTH):
  - The full_adder takes shA[0], shB[0] and the carry flip-flop.
  - Its Sum bit is shifted into the MSB of the sum shift register, its Cout goes to the carry flip-flop, shA and shB shift right, and the counter increments.
- On edge E(WIDTH) the block processes the final bit and then:
  - Sum <= the complete shifted result (the final bit included).
  - Cout <= the final full_adder Cout.
  - done <= 1, busy <= 0, and state goes to DONE.
  - Result: done is high in the cycle after E(WIDTH), exactly WIDTH edges after the start edge.
- done is high for exactly one cycle. It clears at the next edge unless a back-to-back completion occurs, which is impossible for WIDTH >= 1.
- start while busy=1 is ignored, and the operands are not resampled.
- Back-to-back: start=1 during the DONE cycle is accepted. That edge is the new E0, so busy rises in the same cycle as done falls.
- Changes to A, B and Cin after E0 have no effect on the current addition.
- Arithmetic: {Cout, Sum} = A + B + Cin modulo 2^(WIDTH+1). There is no overflow flag.
- WIDTH=1: done appears one edge after the start edge.

Decomposition:
- Package serial_adder_pkg holds:
  - the state encodings IDLE=2'd0, RUN=2'd1 and DONE=2'd2 (2'd3 is illegal and decodes to IDLE);
  - the counter-width helper.
- One sub-module: the team's existing full_adder cell, instantiated once.
- All sequencing, shifting and the carry flip-flop live in serial_adder.

Test Plan:
- WIDTH=8; A=0x3C, B=0x5A, Cin=0, start pulsed at E0 -> done=1 after E8, Sum=0x96, Cout=0, busy high for E0..E7.
- A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1; repeat with A=0xFF, B=0x00, Cin=1 -> Sum=0x00, Cout=1.
- Start accepted, then A/B changed and start re-pulsed at E3 -> the result equals the original operands' sum, and only one done pulse occurs.
- Drop rst_n at E4 mid-RUN, release it, and wait 12 cycles -> no done pulse, and Sum=0, Cout=0, busy=0 throughout.
- Back-to-back: hold start=1 with 0x10+0x20, then 0x80+0x80 -> done after E8 (Sum=0x30, Cout=0), second done 8 edges later (Sum=0x00, Cout=1).
- Random regression: 1000 operand/Cin triples at WIDTH=1, 8 and 13 -> {Cout, Sum} matches A+B+Cin, and done arrives exactly WIDTH edges after each accepted start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings and width helper for serial_adder
//
// Purpose: state encoding for the serial adder sequencer and the helper that
//          sizes its bit counter.
// Contents:
//    state_t    - IDLE / RUN / DONE (2'd3 is unused and decodes as IDLE)
//    cnt_width  - bits needed to count 0..width inclusive
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
//
// Purpose: combinational one-bit full adder.
// Ports:
//    a, b  in   operand bits
//    cin   in   carry in
//    sum   out  a ^ b ^ cin
//    cout  out  majority(a, b, cin)
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder behind a start/done handshake
//
// Purpose: adds A + B + Cin one bit per clock, LSB first, through a single
//          full_adder cell and a carry flip-flop.
// Ports:
//    clk    in   rising-edge clock
//    rst_n  in   asynchronous active-low reset
//    start  in   request, sampled only while not busy
//    A, B   in   operands, captured on an accepted start
//    Cin    in   carry-in, captured on an accepted start
//    busy   out  high while an addition is in progress
//    done   out  one-cycle pulse when Sum/Cout are updated
//    Sum    out  registered sum, held until the next completion
//    Cout   out  registered carry-out, held with Sum
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] sh_s;
   logic [WIDTH-1:0] sh_s_nxt;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_sum;
   logic             fa_cout;
   logic             accept;
   logic             last;

   full_adder u_fa (
      .a    (sh_a[0]),
      .b    (sh_b[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New sum bit enters at the MSB so that after WIDTH shifts the first
   // (LSB) result bit has reached bit 0. Written as shift-then-overwrite so
   // it also holds for WIDTH=1.
   always_comb begin
      sh_s_nxt            = sh_s >> 1;
      sh_s_nxt[WIDTH-1]   = fa_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         RUN: begin
            last = (cnt == CNT_W'(WIDTH - 1));
            if (last) begin
               state_nxt = DONE;
            end
         end
         default: begin
            // IDLE, DONE and the unused encoding all behave as idle:
            // a start in the DONE cycle gives back-to-back operation.
            accept    = start;
            state_nxt = start ? RUN : IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a  <= '0;
         sh_b  <= '0;
         sh_s  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         done  <= 1'b0;
         Sum   <= '0;
         Cout  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            sh_a  <= A;
            sh_b  <= B;
            sh_s  <= '0;
            carry <= Cin;
            cnt   <= '0;
         end else if (state == RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            sh_s  <= sh_s_nxt;
            carry <= fa_cout;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
               Sum  <= sh_s_nxt;
               Cout <= fa_cout;
               done <= 1'b1;
            end
         end
      end
   end

   assign busy = (state == RUN);

endmodule
